// File: rtl/count7_seq_monitor_if.sv
// count7_seq_monitor_if
//   Bundle between a 7-state counter and its downstream sequence monitor.
//   master : counter/test side, drives count_in and observes the status.
//   slave  : monitor side, samples count_in and drives the status.
//   Signals:
//     count_in     [2:0]      counter value, stable before each rising edge
//     locked                  sequence tracking established
//     err                     one-cycle pulse on a sequence violation while locked
//     wrap                    one-cycle pulse on a legal end-of-period step while locked
//     cycles       [CYC_W-1:0] completed periods while locked (modulo 2^CYC_W)
//     illegal_seen            sticky, the skipped code was sampled
//     err_cnt      [3:0]      saturating error count
interface count7_seq_monitor_if #(
  parameter int CYC_W = 8
);
  logic [2:0]       count_in;
  logic             locked;
  logic             err;
  logic             wrap;
  logic [CYC_W-1:0] cycles;
  logic             illegal_seen;
  logic [3:0]       err_cnt;

  modport master (
    output count_in,
    input  locked, err, wrap, cycles, illegal_seen, err_cnt
  );

  modport slave (
    input  count_in,
    output locked, err, wrap, cycles, illegal_seen, err_cnt
  );
endinterface

// File: rtl/count7_seq_monitor.sv
// count7_seq_monitor
//   Checks that a 3-bit, 7-state counter steps through its legal sequence.
//   Acquires lock after LOCK_CYCLES consecutive correct steps, then reports
//   sequence errors, legal end-of-period wraps and completed periods, and
//   flags any sample of the code the counter must never produce.
//
//   Parameters:
//     SKIP_STATE  : the one 3-bit code the counter never visits
//     LOCK_CYCLES : consecutive correct steps needed for lock (1..7)
//     CYC_W       : width of the completed-period counter
//
//   Ports:
//     clk  : rising-edge clock
//     rstb : synchronous active-low reset
//     mon  : count7_seq_monitor_if.slave (count_in in, status out)
//
//   Build option:
//     COUNT7_MON_ERRCNT_EN : when defined, err_cnt is a saturating 4-bit
//     register; when undefined, err_cnt is tied to zero and has no flops.
module count7_seq_monitor #(
  parameter logic [2:0] SKIP_STATE  = 3'd7,
  parameter int         LOCK_CYCLES = 2,
  parameter int         CYC_W       = 8
) (
  input  logic                clk,
  input  logic                rstb,
  count7_seq_monitor_if.slave mon
);

  localparam logic [2:0] LOCK_N = LOCK_CYCLES[2:0];

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       prev_q;
  logic [2:0]       match_cnt_q, match_cnt_d;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;
  logic [CYC_W-1:0] cycles_q, cycles_d;
  logic             illegal_q, illegal_d;
  logic             is_match;
  logic             is_wrap;

  // Legal successor; the skipped code is jumped over.
  function automatic logic [2:0] succ(input logic [2:0] s);
    logic [2:0] n;
    n = s + 3'd1;
    if (n == SKIP_STATE) n = s + 3'd2;
    return n;
  endfunction

`ifdef COUNT7_MON_ERRCNT_EN
  logic [3:0] err_cnt_q, err_cnt_d;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction
`endif

  // Next-state and flag decode
  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    err_d       = 1'b0;
    wrap_d      = 1'b0;
    cycles_d    = cycles_q;
    illegal_d   = illegal_q | (mon.count_in == SKIP_STATE);
`ifdef COUNT7_MON_ERRCNT_EN
    err_cnt_d   = err_cnt_q;
`endif
    // The skipped code is never a match, even from a prev that would
    // otherwise lead to it.
    is_match = (mon.count_in == succ(prev_q)) && (mon.count_in != SKIP_STATE);
    is_wrap  = is_match && (mon.count_in < prev_q);

    unique case (state_q)
      SEARCH: begin
        state_d = ACQUIRE;
      end
      ACQUIRE: begin
        if (is_match) begin
          if (match_cnt_q + 3'd1 == LOCK_N) begin
            state_d     = LOCKED;
            match_cnt_d = 3'd0;
          end else begin
            match_cnt_d = match_cnt_q + 3'd1;
          end
        end else begin
          match_cnt_d = 3'd0;
        end
      end
      LOCKED: begin
        if (is_match) begin
          if (is_wrap) begin
            wrap_d   = 1'b1;
            cycles_d = cycles_q + {{(CYC_W-1){1'b0}}, 1'b1};
          end
        end else begin
          err_d       = 1'b1;
          match_cnt_d = 3'd0;
          state_d     = ACQUIRE;
`ifdef COUNT7_MON_ERRCNT_EN
          err_cnt_d   = sat_inc4(err_cnt_q);
`endif
        end
      end
      default: begin
        state_d     = SEARCH;
        match_cnt_d = 3'd0;
      end
    endcase
  end

  // Registered state and status
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= SEARCH;
      prev_q      <= 3'd0;
      match_cnt_q <= 3'd0;
      err_q       <= 1'b0;
      wrap_q      <= 1'b0;
      cycles_q    <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= mon.count_in;
      match_cnt_q <= match_cnt_d;
      err_q       <= err_d;
      wrap_q      <= wrap_d;
      cycles_q    <= cycles_d;
      illegal_q   <= illegal_d;
    end
  end

`ifdef COUNT7_MON_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (!rstb) err_cnt_q <= 4'd0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign mon.err_cnt = err_cnt_q;
`else
  assign mon.err_cnt = 4'd0;
`endif

  assign mon.locked       = (state_q == LOCKED);
  assign mon.err          = err_q;
  assign mon.wrap         = wrap_q;
  assign mon.cycles       = cycles_q;
  assign mon.illegal_seen = illegal_q;

endmodule

// File: tb/tb_count7_seq_monitor.sv
// tb_count7_seq_monitor
//   Table of directed vectors with literal expected outputs, then model-driven
//   sequences (repeated faults, cycles roll-over, random traffic with resets).
//   Expected outputs are queued when each input is driven and popped when the
//   DUT output is sampled 1 time unit after the rising edge.
module tb_count7_seq_monitor;

  localparam logic [2:0] SKIP = 3'd7;
  localparam int         LOCK = 2;

`ifdef COUNT7_MON_ERRCNT_EN
  localparam bit ERRCNT_EN = 1'b1;
`else
  localparam bit ERRCNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic       locked;
    logic       err;
    logic       wrap;
    logic [7:0] cycles;
    logic       ill;
    logic [3:0] ecnt;
  } outs_t;

  typedef struct {
    logic       rstb;
    logic [2:0] cnt;
    outs_t      exp;
  } vec_t;

  logic clk = 1'b0;
  logic rstb = 1'b0;

  count7_seq_monitor_if #(.CYC_W(8)) bus ();

  count7_seq_monitor #(
    .SKIP_STATE (SKIP),
    .LOCK_CYCLES(LOCK),
    .CYC_W      (8)
  ) dut (
    .clk (clk),
    .rstb(rstb),
    .mon (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int err_pulses = 0;
  int wrap_pulses = 0;

  outs_t exp_q[$];
  string nm_q[$];

  // Reference model state
  int         m_state = 0;  // 0 search, 1 acquire, 2 locked
  logic [2:0] m_prev  = 3'd0;
  int         m_mcnt  = 0;
  outs_t      m_out   = '0;

  function automatic logic [2:0] nxt(input logic [2:0] s);
    logic [2:0] n;
    n = s + 3'd1;
    if (n == SKIP) n = n + 3'd1;
    return n;
  endfunction

  task automatic model_step(input logic r, input logic [2:0] c);
    bit m;
    if (!r) begin
      m_state = 0; m_prev = 3'd0; m_mcnt = 0; m_out = '0;
      return;
    end
    m_out.err  = 1'b0;
    m_out.wrap = 1'b0;
    if (c == SKIP) m_out.ill = 1'b1;
    m = (c != SKIP) && (c == nxt(m_prev));
    if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (!m) m_mcnt = 0;
      else if (m_mcnt + 1 >= LOCK) begin m_state = 2; m_mcnt = 0; end
      else m_mcnt = m_mcnt + 1;
    end else begin
      if (!m) begin
        m_out.err = 1'b1;
        m_mcnt = 0;
        m_state = 1;
        if (ERRCNT_EN && m_out.ecnt != 4'd15) m_out.ecnt = m_out.ecnt + 4'd1;
      end else if (c < m_prev) begin
        m_out.wrap = 1'b1;
        m_out.cycles = m_out.cycles + 8'd1;
      end
    end
    m_prev = c;
    m_out.locked = (m_state == 2);
  endtask

  task automatic cmp_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic check_out();
    outs_t act, e;
    string nm;
    act = {bus.locked, bus.err, bus.wrap, bus.cycles, bus.illegal_seen, bus.err_cnt};
    if (act.err)  err_pulses++;
    if (act.wrap) wrap_pulses++;
    if (exp_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: output with no queued expectation");
      return;
    end
    e  = exp_q.pop_front();
    nm = nm_q.pop_front();
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got locked=%0b err=%0b wrap=%0b cycles=%0d ill=%0b err_cnt=%0d, want locked=%0b err=%0b wrap=%0b cycles=%0d ill=%0b err_cnt=%0d",
               nm, act.locked, act.err, act.wrap, act.cycles, act.ill, act.ecnt,
               e.locked, e.err, e.wrap, e.cycles, e.ill, e.ecnt);
    end
  endtask

  // Drive one edge with a given expectation.
  task automatic drive(input logic r, input logic [2:0] c, input outs_t e, input string nm);
    @(negedge clk);
    rstb = r;
    bus.count_in = c;
    exp_q.push_back(e);
    nm_q.push_back(nm);
    @(posedge clk);
    #1;
    check_out();
  endtask

  // Drive one edge with the model's expectation.
  task automatic drive_m(input logic r, input logic [2:0] c, input string nm);
    model_step(r, c);
    drive(r, c, m_out, nm);
  endtask

  function automatic vec_t v(input logic r, input logic [2:0] c, input logic l,
                             input logic e, input logic w, input logic [7:0] cy,
                             input logic il, input logic [3:0] ec);
    vec_t t;
    t.rstb = r;
    t.cnt  = c;
    t.exp  = {l, e, w, cy, il, (ERRCNT_EN ? ec : 4'd0)};
    return t;
  endfunction

  vec_t tbl[38];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rstb cnt  lck err wrp cyc ill ecnt
    tbl[0]  = v(0, 3'd5, 0, 0, 0, 8'd0, 0, 4'd0);  // reset held
    tbl[1]  = v(0, 3'd5, 0, 0, 0, 8'd0, 0, 4'd0);
    tbl[2]  = v(1, 3'd0, 0, 0, 0, 8'd0, 0, 4'd0);  // SEARCH capture
    tbl[3]  = v(1, 3'd1, 0, 0, 0, 8'd0, 0, 4'd0);
    tbl[4]  = v(1, 3'd2, 1, 0, 0, 8'd0, 0, 4'd0);  // lock
    tbl[5]  = v(1, 3'd3, 1, 0, 0, 8'd0, 0, 4'd0);
    tbl[6]  = v(1, 3'd4, 1, 0, 0, 8'd0, 0, 4'd0);
    tbl[7]  = v(1, 3'd5, 1, 0, 0, 8'd0, 0, 4'd0);
    tbl[8]  = v(1, 3'd6, 1, 0, 0, 8'd0, 0, 4'd0);
    tbl[9]  = v(1, 3'd0, 1, 0, 1, 8'd1, 0, 4'd0);  // wrap 1
    tbl[10] = v(1, 3'd1, 1, 0, 0, 8'd1, 0, 4'd0);
    tbl[11] = v(1, 3'd2, 1, 0, 0, 8'd1, 0, 4'd0);
    tbl[12] = v(1, 3'd3, 1, 0, 0, 8'd1, 0, 4'd0);
    tbl[13] = v(1, 3'd4, 1, 0, 0, 8'd1, 0, 4'd0);
    tbl[14] = v(1, 3'd5, 1, 0, 0, 8'd1, 0, 4'd0);
    tbl[15] = v(1, 3'd6, 1, 0, 0, 8'd1, 0, 4'd0);
    tbl[16] = v(1, 3'd0, 1, 0, 1, 8'd2, 0, 4'd0);  // wrap 2
    tbl[17] = v(1, 3'd1, 1, 0, 0, 8'd2, 0, 4'd0);
    tbl[18] = v(1, 3'd2, 1, 0, 0, 8'd2, 0, 4'd0);
    tbl[19] = v(1, 3'd3, 1, 0, 0, 8'd2, 0, 4'd0);
    tbl[20] = v(1, 3'd4, 1, 0, 0, 8'd2, 0, 4'd0);
    tbl[21] = v(1, 3'd5, 1, 0, 0, 8'd2, 0, 4'd0);
    tbl[22] = v(1, 3'd6, 1, 0, 0, 8'd2, 0, 4'd0);
    tbl[23] = v(1, 3'd0, 1, 0, 1, 8'd3, 0, 4'd0);  // wrap 3
    tbl[24] = v(1, 3'd1, 1, 0, 0, 8'd3, 0, 4'd0);
    tbl[25] = v(1, 3'd2, 1, 0, 0, 8'd3, 0, 4'd0);
    tbl[26] = v(1, 3'd3, 1, 0, 0, 8'd3, 0, 4'd0);
    tbl[27] = v(1, 3'd4, 1, 0, 0, 8'd3, 0, 4'd0);
    tbl[28] = v(1, 3'd2, 0, 1, 0, 8'd3, 0, 4'd1);  // fault 4->2
    tbl[29] = v(1, 3'd3, 0, 0, 0, 8'd3, 0, 4'd1);
    tbl[30] = v(1, 3'd4, 1, 0, 0, 8'd3, 0, 4'd1);  // relock
    tbl[31] = v(1, 3'd7, 0, 1, 0, 8'd3, 1, 4'd2);  // illegal code
    tbl[32] = v(1, 3'd0, 0, 0, 0, 8'd3, 1, 4'd2);  // succ(7)=0
    tbl[33] = v(1, 3'd1, 1, 0, 0, 8'd3, 1, 4'd2);
    tbl[34] = v(0, 3'd3, 0, 0, 0, 8'd0, 0, 4'd0);  // reset mid-run
    tbl[35] = v(1, 3'd0, 0, 0, 0, 8'd0, 0, 4'd0);
    tbl[36] = v(1, 3'd1, 0, 0, 0, 8'd0, 0, 4'd0);
    tbl[37] = v(1, 3'd2, 1, 0, 0, 8'd0, 0, 4'd0);

    bus.count_in = 3'd0;
    rstb = 1'b0;

    for (int i = 0; i < 38; i++) begin
      model_step(tbl[i].rstb, tbl[i].cnt);
      drive(tbl[i].rstb, tbl[i].cnt, tbl[i].exp, $sformatf("vec%0d", i));
    end
    cmp_int("table_wrap_pulses", wrap_pulses, 3);
    cmp_int("table_err_pulses", err_pulses, 2);

    // Twenty isolated faults, each followed by a relock.
    err_pulses = 0;
    for (int i = 0; i < 20; i++) begin
      drive_m(1'b1, nxt(nxt(m_prev)), $sformatf("sat_fault%0d", i));
      for (int k = 0; k < LOCK; k++)
        drive_m(1'b1, nxt(m_prev), $sformatf("sat_relock%0d_%0d", i, k));
    end
    cmp_int("sat_err_pulses", err_pulses, 20);
    cmp_int("sat_err_cnt", int'(bus.err_cnt), ERRCNT_EN ? 15 : 0);
    cmp_int("sat_locked", int'(bus.locked), 1);

    // Enough full periods to roll the 8-bit cycles counter over.
    wrap_pulses = 0;
    for (int i = 0; i < 260 * 7; i++)
      drive_m(1'b1, nxt(m_prev), "rollover");
    cmp_int("rollover_wrap_pulses", wrap_pulses, 260);
    cmp_int("rollover_cycles", int'(bus.cycles), 4);

    // Random traffic: mostly legal steps, occasional bad codes and resets.
    for (int i = 0; i < 400; i++) begin
      logic       r;
      logic [2:0] c;
      r = ($urandom_range(0, 59) != 0);
      c = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : nxt(m_prev);
      drive_m(r, c, $sformatf("rand%0d", i));
    end

    cmp_int("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/count7_seq_monitor.md
# count7_seq_monitor

Downstream checker for the 3-bit, 7-state counter.
- Samples the counter's `count` output every clock and verifies that each step follows the legal 7-state sequence.
- Acquires and reports lock, flags sequence errors and illegal codes, and counts completed counting periods.
- Shares `clk` and `rstb` with the counter and feeds status to the test/debug logic.

## Interface
Parameters:
- `SKIP_STATE`, default 3'd7: the one 3-bit code the counter never visits.
- `LOCK_CYCLES`, default 2, range 1–7: consecutive correct transitions required to declare lock.
- `CYC_W`, default 8: width of the completed-period counter.

Ports:
- `clk` input 1: rising-edge clock.
- `rstb` input 1: reset. One clock; reset is synchronous and active-low.
- `count_in` input 3: counter value, stable before each rising edge.
- `locked` output 1: sequence tracking established.
- `err` output 1: one-cycle pulse on a sequence violation while locked.
- `wrap` output 1: one-cycle pulse on a legal end-of-period transition while locked.
- `cycles` output CYC_W: completed periods while locked; wraps modulo 2^CYC_W.
- `illegal_seen` output 1: sticky flag, set when `SKIP_STATE` is sampled.
- `err_cnt` output 4: saturating error count.

## Operation
- succ(s) is (s+1) mod 8. If that value equals `SKIP_STATE`, succ(s) is (s+2) mod 8.
- Register `prev` holds the sample from the previous edge. A sample "matches" when `count_in` == succ(prev).
- A legal wrap is a matching sample whose value is numerically less than `prev`. Examples: 6→0 for SKIP=7; 7→1 for SKIP=0.

FSM states:
- SEARCH (reset state): capture `count_in` into `prev`, then go to ACQUIRE. No compare is made.
- ACQUIRE:
  - On a match, increment `match_cnt`.
  - When `match_cnt` reaches `LOCK_CYCLES` on this edge, go to LOCKED and clear `match_cnt`.
  - On a mismatch, clear `match_cnt` and stay in ACQUIRE.
- LOCKED:
  - On a match, stay. On a legal wrap, pulse `wrap` and increment `cycles`.
  - On a mismatch, pulse `err`, increment `err_cnt` (saturating at 15), clear `match_cnt`, and go to ACQUIRE.

General rules:
- `prev` is updated with `count_in` on every non-reset edge, in every state.
- Sampling `SKIP_STATE` sets `illegal_seen`. It is always a mismatch and cannot be a wrap.
- `locked` is high exactly when the FSM is in LOCKED.
- `err` and `wrap` can never be high in the same cycle.
- `cycles` and `err_cnt` change only in LOCKED, except for reset.

## Timing
- All outputs are registered and update on the rising edge that samples the relevant `count_in`.
- Latency from sample to flag is 0 cycles after that edge, i.e. flags are visible in the following clock period.
- Reset values: `locked` 0, `err` 0, `wrap` 0, `cycles` 0, `illegal_seen` 0, `err_cnt` 0. FSM = SEARCH, `prev` = 0, `match_cnt` = 0.
- `rstb` is checked first on every edge. Reset mid-operation abandons any state on that edge, and the next non-reset edge is treated as SEARCH.
- If the counter alone is reset (e.g. 4→0 while locked), the monitor sees an ordinary mismatch: `err` pulses and the monitor relocks after `LOCK_CYCLES` further correct steps.
- `cycles` wrap-around is silent: from 2^CYC_W−1 it goes to 0 with no extra flag.
- `err_cnt` holds at 15. Further errors still pulse `err`.

## Configuration
- `COUNT7_MON_ERRCNT_EN` defined: the `err_cnt` register and its saturating increment are compiled in.
- `COUNT7_MON_ERRCNT_EN` undefined:
  - `err_cnt` is tied to 4'd0 and has no flops.
  - All other behaviour is unchanged, including the `err` pulses.

## Test plan
Defaults for all scenarios: SKIP_STATE=7, LOCK_CYCLES=2, CYC_W=8, macro defined.
- Reset: hold `rstb`=0 for 2 edges with `count_in`=5 → all outputs 0, `locked`=0.
- Acquire: release reset and drive 0,1,2 on consecutive edges → `locked` rises after the edge sampling 2; `err`=0 throughout.
- Periods: continue 3,4,5,6,0 → `wrap` is high for exactly 1 cycle after sampling 0 and `cycles`=1. After 14 more correct samples, `cycles`=3 and exactly 3 `wrap` pulses have occurred.
- Fault and relock:
  - While locked after 4, drive 2 → `err` pulses once, `err_cnt`=1, `locked`=0.
  - Then drive 3,4 → `locked`=1 again.
  - Then drive 7 → `illegal_seen`=1, `err` pulses, `err_cnt`=2.
- Saturation: inject 20 isolated faults, each separated by a relock → `err_cnt`=15 and 20 `err` pulses. Macro undefined → `err_cnt` stays 0.
- Reset mid-run: while locked with `cycles`=3, drive `rstb`=0 for 1 edge → all outputs 0 the next cycle. The relock sequence then matches the Acquire scenario.
